// File: rtl/alu_if.sv
// ALU operand/result bundle: operation select and operands flow toward the
// ALU, the registered result and signed-overflow flag flow back.
interface alu_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             overflow;

  // Requester side: drives the operation, observes the outcome.
  modport master (
    output control,
    output a,
    output b,
    input  result,
    input  overflow
  );

  // ALU side: consumes the operation, drives the outcome.
  modport slave (
    input  control,
    input  a,
    input  b,
    output result,
    output overflow
  );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU: ADD, SUB, AND, XOR on two's-complement
// operands with a signed-overflow flag. The unsigned carry-out is dropped
// on purpose; overflow is derived purely from operand/result sign bits.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       control_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_d;
  logic             overflow_d;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  // Signed overflow for an addition x + y (y already inverted for SUB):
  // operands agree in sign but the wrapped sum does not.
  function automatic logic add_ovf(input logic x_msb, input logic y_msb,
                                   input logic r_msb);
    add_ovf = (x_msb == y_msb) && (r_msb != x_msb);
  endfunction

  assign control_s = bus.control;
  assign a_s       = bus.a;
  assign b_s       = bus.b;

  // Subtraction reuses the adder form a + ~b + 1; both wrap modulo 2^WIDTH.
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s + ~b_s + ONE;

  // Select the next result and overflow flag from the current operation.
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (control_s)
      OP_ADD: begin
        result_d   = sum_s;
        overflow_d = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        result_d   = diff_s;
        overflow_d = add_ovf(a_s[WIDTH-1], ~b_s[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND: begin
        result_d   = a_s & b_s;
        overflow_d = 1'b0;
      end
      OP_XOR: begin
        result_d   = a_s ^ b_s;
        overflow_d = 1'b0;
      end
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset wins over any operation presented the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: each step drives one operation on
// the falling edge, queues its expected outcome, and checks it just after
// the following rising edge.
module tb_alu;

  localparam int WIDTH = 64;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2;
  localparam logic [1:0] XOR = 2'd3;

  localparam logic [WIDTH-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [WIDTH-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [WIDTH-1:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [WIDTH-1:0] M4   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [WIDTH-1:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [WIDTH-1:0] M6   = 64'hFFFF_FFFF_FFFF_FFFA;

  logic clk;
  logic rst;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] exp_res_q[$];
  logic             exp_ovf_q[$];
  string            exp_tag_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the oldest queued expectation against the DUT outputs.
  task automatic check_next();
    logic [WIDTH-1:0] er;
    logic             eo;
    string            tag;
    if (exp_res_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: empty queue at check, got result %h", bus.result);
    end else begin
      er  = exp_res_q.pop_front();
      eo  = exp_ovf_q.pop_front();
      tag = exp_tag_q.pop_front();
      tests_run++;
      assert (bus.result === er) else begin
        tests_failed++;
        $error("FAIL %s result: got %h expected %h", tag, bus.result, er);
      end
      tests_run++;
      assert (bus.overflow === eo) else begin
        tests_failed++;
        $error("FAIL %s overflow: got %b expected %b", tag, bus.overflow, eo);
      end
    end
  endtask

  // One cycle: drive inputs and rst on the falling edge, queue the expected
  // outcome, then check it one rising edge later.
  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [WIDTH-1:0] er, input logic eo);
    @(negedge clk);
    rst         = r;
    bus.control = op;
    bus.a       = av;
    bus.b       = bv;
    exp_res_q.push_back(er);
    exp_ovf_q.push_back(eo);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_next();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.control  = ADD;
    bus.a        = MAXP;
    bus.b        = MAXP;

    // Reset state, with overflowing operands present to prove they are ignored.
    step("reset",        1'b1, ADD, MAXP, MAXP, '0, 1'b0);

    // First operation after reset, then back-to-back traffic every cycle.
    step("add_no_ovf",   1'b0, ADD, MINN, MAXP, M1, 1'b0);
    step("add_m1_m5",    1'b0, ADD, M1, M5, M6, 1'b0);
    step("add_1_m5",     1'b0, ADD, 64'd1, M5, M4, 1'b0);
    step("add_ovf_pos",  1'b0, ADD, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step("add_ovf_neg",  1'b0, ADD, MINN, 64'h8000_0000_0000_0001, 64'd1, 1'b1);
    step("sub_5_1",      1'b0, SUB, 64'd5, 64'd1, 64'd4, 1'b0);
    step("sub_m1_m5",    1'b0, SUB, M1, M5, 64'd4, 1'b0);
    step("sub_ovf_pos",  1'b0, SUB, MAXP, M5, 64'h8000_0000_0000_0004, 1'b1);
    step("sub_ovf_neg",  1'b0, SUB, MINN, 64'd1, MAXP, 1'b1);
    step("sub_zero",     1'b0, SUB, 64'd0, 64'd0, 64'd0, 1'b0);
    step("and",          1'b0, AND, MAXP, M5, 64'h7FFF_FFFF_FFFF_FFFB, 1'b0);
    step("xor_big",      1'b0, XOR, MINN, M5, 64'h7FFF_FFFF_FFFF_FFFB, 1'b0);
    step("xor_1_5",      1'b0, XOR, 64'd1, 64'd5, 64'd4, 1'b0);

    // Overflowing ADD, then a one-cycle reset discards the next operation.
    step("pre_rst_ovf",  1'b0, ADD, MAXP, 64'd1, MINN, 1'b1);
    step("mid_rst",      1'b1, ADD, MAXP, MAXP, '0, 1'b0);
    step("post_rst",     1'b0, SUB, 64'd1, 64'd5, M4, 1'b0);
    step("post_rst_and", 1'b0, AND, M1, 64'h0000_0000_FFFF_0000,
         64'h0000_0000_FFFF_0000, 1'b0);

    tests_run++;
    assert (exp_res_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain: %0d left expected 0", exp_res_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port control, input, 2 bits: operation select (0 ADD, 1 SUB, 2 AND, 3 XOR).
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, two's-complement signed.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, two's-complement signed.
REQ-007 The block SHALL have port result, output, WIDTH bits: registered operation result, signed.
REQ-008 The block SHALL have port overflow, output, 1 bit: registered signed-overflow flag for result.

Function
REQ-009 The block SHALL sample control, a and b on every rising clk edge with rst low, and update result and overflow from them.
- Latency: exactly 1 cycle.
- No handshake; a new operation is accepted every cycle.
REQ-010 The block SHALL compute ADD (control=0) as result = (a + b) mod 2^WIDTH.
REQ-011 The block SHALL compute SUB (control=1) as result = (a - b) mod 2^WIDTH, implemented as a + ~b + 1.
REQ-012 The block SHALL compute AND (control=2) as result = bitwise a & b.
REQ-013 The block SHALL compute XOR (control=3) as result = bitwise a ^ b.
REQ-014 For ADD, the block SHALL set overflow = 1 exactly when a[MSB] == b[MSB] and result[MSB] != a[MSB].
REQ-015 For SUB, the block SHALL set overflow = 1 exactly when a[MSB] != b[MSB] and result[MSB] != a[MSB].
REQ-016 For AND and XOR, the block SHALL drive overflow = 0.
REQ-017 On overflow, the block SHALL still output the wrapped WIDTH-bit result; there is no saturation.
REQ-018 The block SHALL NOT expose the unsigned carry-out and SHALL NOT let it affect overflow.
REQ-019 The datapath between the input sample and the output registers SHALL be purely combinational, with no other internal state.

Reset
REQ-020 When rst is high at a rising clk edge, the block SHALL load result = 0 and overflow = 0, ignoring the inputs.
REQ-021 Reset SHALL take priority over any operation in the same cycle.
REQ-022 The first operation after rst deasserts SHALL appear on the outputs one cycle after it is sampled.
REQ-023 Asserting reset mid-stream SHALL discard the in-flight result.
REQ-024 Before the first clock edge with rst high, the outputs SHALL be unspecified.

Verification
REQ-025 The bench SHALL cover ADD without overflow: 0x8000_0000_0000_0000 + 0x7FFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFF (-1), overflow 0.
REQ-026 The bench SHALL cover ADD of mixed signs: -1 + -5 -> result -6, overflow 0; also 1 + -5 -> result -4, overflow 0.
REQ-027 The bench SHALL cover ADD with overflow:
- 0x7FFF_FFFF_FFFF_FFFF + 0x7FFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE, overflow 1.
- 0x8000_0000_0000_0000 + 0x8000_0000_0000_0001 -> result 0x0000_0000_0000_0001, overflow 1.
REQ-028 The bench SHALL cover SUB:
- 5 - 1 -> result 4, overflow 0.
- -1 - -5 -> result 4, overflow 0.
- 0x7FFF_FFFF_FFFF_FFFF - (-5) -> result 0x8000_0000_0000_0004, overflow 1.
REQ-029 The bench SHALL cover logic ops:
- AND 0x7FFF_FFFF_FFFF_FFFF & 0xFFFF_FFFF_FFFF_FFFB -> result 0x7FFF_FFFF_FFFF_FFFB, overflow 0.
- XOR 0x8000_0000_0000_0000 ^ 0xFFFF_FFFF_FFFF_FFFB -> result 0x7FFF_FFFF_FFFF_FFFB, overflow 0.
- XOR 1 ^ 5 -> result 4, overflow 0.
REQ-030 The bench SHALL cover reset and latency:
- Apply an overflowing ADD, then assert rst for one cycle -> result 0 and overflow 0 on the next edge.
- Back-to-back operations on consecutive cycles -> each result appears exactly one cycle after its inputs are sampled.
